low_pass_mc: RTL

Multi-channel, runtime-configurable moving-average low-pass filter for laser sample streams. It generalises the fixed single-channel low-pass stage in three ways: CH_NUM parallel lanes share one valid strobe; the window length is selectable at runtime as a power of two; and there is a bypass mode. It sits between the laser ADC capture path and downstream decimation/packing, and accepts one sample vector per valid cycle at full clock rate.

---
 rtl/low_pass_mc.sv | 136 +++++++++++++
 1 files changed

// File: rtl/low_pass_mc.sv
// Multi-channel moving-average low-pass filter with runtime power-of-two window,
// bypass and window restart. Three register stages: input capture, RAM access, accumulate.
module low_pass_mc #(
  parameter int CH_NUM       = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int LP_DEPTH_MAX = 8,
  parameter int ROUND        = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             laser_vld_i,
  input  logic [CH_NUM*DATA_WIDTH-1:0]     laser_data_i,
  input  logic [$clog2(LP_DEPTH_MAX+1)-1:0] lp_depth_i,
  input  logic                             lp_bypass_i,
  input  logic                             lp_clr_i,
  output logic                             lp_laser_vld_o,
  output logic [CH_NUM*DATA_WIDTH-1:0]     lp_laser_data_o,
  output logic                             lp_settled_o
);

  localparam int DW = $clog2(LP_DEPTH_MAX + 1);
  localparam int AW = LP_DEPTH_MAX;
  localparam int W  = DATA_WIDTH;
  localparam int SW = DATA_WIDTH + LP_DEPTH_MAX;

  // stage 0: captured inputs
  logic                vld0_q, clr0_q, byp0_q;
  logic [DW-1:0]       dep0_q, dep_clamp;
  logic [CH_NUM*W-1:0] x0_q;
  // stage 1: shared window control
  logic [AW-1:0]       wr_ptr_q, rd_addr;
  logic [AW:0]         fill_q, fill_d, win_len;
  logic [DW-1:0]       d_q;
  logic                pend_q, restart, restart_req;
  logic                vld1_q, restart1_q, use_y1_q, settled1_q, byp1_q;
  // stage 2
  logic                vld2_q, settled_q;

  assign dep_clamp = (lp_depth_i > DW'(LP_DEPTH_MAX)) ? DW'(LP_DEPTH_MAX) : lp_depth_i;

  always_comb begin
    win_len     = (AW+1)'(1) << dep0_q;
    restart_req = clr0_q | (dep0_q != d_q);
    restart     = restart_req | pend_q;
    fill_d      = restart ? (AW+1)'(1)
                          : ((fill_q == win_len) ? fill_q : fill_q + (AW+1)'(1));
    // At full depth this equals wr_ptr_q; read-first RAM then returns the evicted sample.
    rd_addr     = wr_ptr_q - win_len[AW-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld0_q     <= 1'b0;
      clr0_q     <= 1'b0;
      byp0_q     <= 1'b0;
      dep0_q     <= '0;
      x0_q       <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      d_q        <= '0;
      pend_q     <= 1'b0;
      vld1_q     <= 1'b0;
      restart1_q <= 1'b0;
      use_y1_q   <= 1'b0;
      settled1_q <= 1'b0;
      byp1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      settled_q  <= 1'b0;
    end else begin
      vld0_q <= laser_vld_i;
      clr0_q <= lp_clr_i;
      byp0_q <= lp_bypass_i;
      dep0_q <= dep_clamp;
      if (laser_vld_i) x0_q <= laser_data_i;

      vld1_q <= vld0_q;
      if (vld0_q) begin
        wr_ptr_q   <= wr_ptr_q + AW'(1);
        fill_q     <= fill_d;
        d_q        <= dep0_q;
        pend_q     <= 1'b0;
        restart1_q <= restart;
        use_y1_q   <= !restart && (fill_q == win_len);
        settled1_q <= (fill_d == win_len);
        byp1_q     <= byp0_q;
      end else if (restart_req) begin
        pend_q <= 1'b1;
      end

      vld2_q <= vld1_q;
      if (vld1_q) settled_q <= settled1_q;
      if (!vld0_q && restart_req) settled_q <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    logic [W-1:0]  ram [2**AW];
    logic [W-1:0]  x1_q, y_q, out_q, avg;
    logic [SW-1:0] sum_q, sum_d, rnd;

    always_ff @(posedge clk_i) begin
      if (vld0_q) begin
        ram[wr_ptr_q] <= x0_q[gi*W +: W];
        y_q           <= ram[rd_addr];
      end
    end

    always_comb begin
      sum_d = restart1_q ? SW'(x1_q)
                         : sum_q + SW'(x1_q) - (use_y1_q ? SW'(y_q) : SW'(0));
      rnd = '0;
      if (ROUND != 0 && d_q != '0) rnd = SW'(1) << (d_q - DW'(1));
      avg = W'((sum_d + rnd) >> d_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        x1_q  <= '0;
        sum_q <= '0;
        out_q <= '0;
      end else begin
        if (vld0_q) x1_q <= x0_q[gi*W +: W];
        if (vld1_q) begin
          sum_q <= sum_d;
          out_q <= byp1_q ? x1_q : avg;
        end
      end
    end

    assign lp_laser_data_o[gi*W +: W] = out_q;
  end

  assign lp_laser_vld_o = vld2_q;
  assign lp_settled_o   = settled_q;

endmodule
